uart_rx: RTL

- Serial-to-parallel UART receiver: the receive end of the UART link driven by UART_Tx.
- Frame format: idle-high line; 1 start bit (0); Width data bits, LSB first; optional parity bit; 1 stop bit (1).
- Oversamples RX_IN at Prescale clocks per bit and majority-votes at mid-bit.
- Delivers the parallel word with a one-cycle valid strobe, plus parity and stop error flags.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx_sampler.sv | 63 ++++++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared receiver state encoding, line-level constants and the
//               majority-vote helper used by the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Serial line, parity configuration and parallel result bundle
//               of the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic             RX_IN;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic [WIDTH-1:0] P_data;
    logic             Data_valid;
    logic             PAR_ERR;
    logic             STP_ERR;
    logic             Busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_data, Data_valid, PAR_ERR, STP_ERR, Busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_data, Data_valid, PAR_ERR, STP_ERR, Busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Per-bit edge counter and mid-bit 3-sample majority vote.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  wire logic CLK,
    input  wire logic rst,
    input  wire logic i_run,
    input  wire logic i_rx_s,
    output logic      o_sample_done,
    output logic      o_bit_end,
    output logic      o_vote
);
    localparam int EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] c_smp_a = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] c_smp_b = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] c_smp_c = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] c_last  = EW'(PRESCALE - 1);

    logic [EW-1:0] r_edge_cnt_q, w_edge_cnt_d;
    logic          r_smp_a_q, w_smp_a_d;
    logic          r_smp_b_q, w_smp_b_d;

    // The counter idles at 0 so the first low cycle seen in IDLE is edge 0.
    always_comb begin
        w_edge_cnt_d = '0;
        w_smp_a_d    = r_smp_a_q;
        w_smp_b_d    = r_smp_b_q;
        if (i_run) begin
            w_edge_cnt_d = (r_edge_cnt_q == c_last) ? '0 : r_edge_cnt_q + EW'(1);
        end
        if (r_edge_cnt_q == c_smp_a) begin
            w_smp_a_d = i_rx_s;
        end
        if (r_edge_cnt_q == c_smp_b) begin
            w_smp_b_d = i_rx_s;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_edge_cnt_q <= '0;
            r_smp_a_q    <= 1'b1;
            r_smp_b_q    <= 1'b1;
        end else begin
            r_edge_cnt_q <= w_edge_cnt_d;
            r_smp_a_q    <= w_smp_a_d;
            r_smp_b_q    <= w_smp_b_d;
        end
    end

    assign o_sample_done = (r_edge_cnt_q == c_smp_c);
    assign o_bit_end     = (r_edge_cnt_q == c_last);
    assign o_vote        = maj3(r_smp_a_q, r_smp_b_q, i_rx_s);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver with optional parity, delivering a
//               parallel word plus one-cycle valid / parity / stop strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 8
) (
    input wire logic CLK,
    input wire logic rst,
    uart_rx_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    rx_state_t        r_state_q, w_state_d;
    logic             r_sync1_q, w_sync1_d;
    logic             r_sync2_q, w_sync2_d;
    logic [CW-1:0]    r_bit_cnt_q, w_bit_cnt_d;
    logic [WIDTH-1:0] r_shift_q, w_shift_d;
    logic             r_par_en_q, w_par_en_d;
    logic             r_par_typ_q, w_par_typ_d;
    logic             r_par_bad_q, w_par_bad_d;
    logic             r_stp_bad_q, w_stp_bad_d;
    logic [WIDTH-1:0] r_p_data_q, w_p_data_d;
    logic             r_data_valid_q, w_data_valid_d;
    logic             r_par_err_q, w_par_err_d;
    logic             r_stp_err_q, w_stp_err_d;

    logic w_rx_s;
    logic w_run;
    logic w_sample_done;
    logic w_bit_end;
    logic w_vote;
    logic w_stp_now;

    assign w_rx_s = r_sync2_q;
    assign w_run  = (w_state_d != IDLE);

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .CLK           (CLK),
        .rst           (rst),
        .i_run         (w_run),
        .i_rx_s        (w_rx_s),
        .o_sample_done (w_sample_done),
        .o_bit_end     (w_bit_end),
        .o_vote        (w_vote)
    );

    // With small prescales the stop-bit vote and bit end share a cycle.
    assign w_stp_now = w_sample_done ? (w_vote != STOP_BIT) : r_stp_bad_q;

    always_comb begin
        w_sync1_d      = bus.RX_IN;
        w_sync2_d      = r_sync1_q;
        w_state_d      = r_state_q;
        w_bit_cnt_d    = r_bit_cnt_q;
        w_shift_d      = r_shift_q;
        w_par_en_d     = r_par_en_q;
        w_par_typ_d    = r_par_typ_q;
        w_par_bad_d    = r_par_bad_q;
        w_stp_bad_d    = r_stp_bad_q;
        w_p_data_d     = r_p_data_q;
        w_data_valid_d = 1'b0;
        w_par_err_d    = 1'b0;
        w_stp_err_d    = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (w_rx_s == START_BIT) begin
                    w_state_d   = START;
                    w_bit_cnt_d = '0;
                    w_par_en_d  = bus.PAR_EN;
                    w_par_typ_d = bus.PAR_TYP;
                    w_par_bad_d = 1'b0;
                    w_stp_bad_d = 1'b0;
                end
            end
            START: begin
                if (w_sample_done && (w_vote != START_BIT)) begin
                    w_state_d = IDLE;
                end else if (w_bit_end) begin
                    w_state_d = DATA;
                end
            end
            DATA: begin
                if (w_sample_done) begin
                    w_shift_d = {w_vote, r_shift_q[WIDTH-1:1]};
                end
                if (w_bit_end) begin
                    if (r_bit_cnt_q == c_last_bit) begin
                        w_bit_cnt_d = '0;
                        w_state_d   = r_par_en_q ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (w_sample_done) begin
                    w_par_bad_d = (w_vote != ((^r_shift_q) ^ r_par_typ_q));
                end
                if (w_bit_end) begin
                    w_state_d = STOP;
                end
            end
            STOP: begin
                if (w_sample_done) begin
                    w_stp_bad_d = (w_vote != STOP_BIT);
                end
                if (w_bit_end) begin
                    w_state_d      = IDLE;
                    w_par_err_d    = r_par_bad_q;
                    w_stp_err_d    = w_stp_now;
                    w_data_valid_d = !r_par_bad_q && !w_stp_now;
                    if (w_data_valid_d) begin
                        w_p_data_d = r_shift_q;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_sync1_q      <= 1'b1;
            r_sync2_q      <= 1'b1;
            r_bit_cnt_q    <= '0;
            r_shift_q      <= '0;
            r_par_en_q     <= 1'b0;
            r_par_typ_q    <= 1'b0;
            r_par_bad_q    <= 1'b0;
            r_stp_bad_q    <= 1'b0;
            r_p_data_q     <= '0;
            r_data_valid_q <= 1'b0;
            r_par_err_q    <= 1'b0;
            r_stp_err_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_sync1_q      <= w_sync1_d;
            r_sync2_q      <= w_sync2_d;
            r_bit_cnt_q    <= w_bit_cnt_d;
            r_shift_q      <= w_shift_d;
            r_par_en_q     <= w_par_en_d;
            r_par_typ_q    <= w_par_typ_d;
            r_par_bad_q    <= w_par_bad_d;
            r_stp_bad_q    <= w_stp_bad_d;
            r_p_data_q     <= w_p_data_d;
            r_data_valid_q <= w_data_valid_d;
            r_par_err_q    <= w_par_err_d;
            r_stp_err_q    <= w_stp_err_d;
        end
    end

    assign bus.P_data     = r_p_data_q;
    assign bus.Data_valid = r_data_valid_q;
    assign bus.PAR_ERR    = r_par_err_q;
    assign bus.STP_ERR    = r_stp_err_q;
    assign bus.Busy       = (r_state_q != IDLE);

endmodule
`default_nettype wire
